pc_call_stack_unit: RTL and testbench

- Parametrised next-generation program counter for the CSE664 SoC datapath.
- Supports absolute load, increment, signed relative branch, and subroutine call/return through an internal return-address stack (LIFO).
- Drives the instruction-memory address (count).
- Takes one-hot-ish control strobes from the controller FSM.

---
 rtl/pc_pkg.sv | 35 +++
 rtl/pc_ret_stack.sv | 50 +++++
 rtl/pc_call_stack_unit.sv | 87 ++++++++
 tb/tb_pc_call_stack_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter with return-address stack.
// The decode function turns the controller strobes into a single winning operation.
package pc_pkg;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_BRANCH,
      PC_RET,
      PC_CALL,
      PC_LOAD
   } pc_op_t;

   localparam int PC_ADDR_W_DEF      = 8;
   localparam int PC_STACK_DEPTH_DEF = 4;
   localparam int PC_RESET_PC_DEF    = 0;
   localparam int PC_INC_STEP_DEF    = 1;

   // Fixed priority: load > call > ret > branch > inc > hold.
   function automatic pc_op_t pc_decode(input logic load,
                                        input logic call,
                                        input logic ret,
                                        input logic branch,
                                        input logic inc);
      pc_op_t op;
      if (load)        op = PC_LOAD;
      else if (call)   op = PC_CALL;
      else if (ret)    op = PC_RET;
      else if (branch) op = PC_BRANCH;
      else if (inc)    op = PC_INC;
      else             op = PC_HOLD;
      return op;
   endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO; depth doubles as the stack pointer.
// Push-when-full and pop-when-empty are silently ignored here.
module pc_ret_stack #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4,
   localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1),
   localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [ADDR_W-1:0]  push_data_i,
   output logic [ADDR_W-1:0]  top_o,
   output logic [DEPTH_W-1:0] depth_o,
   output logic               full_o,
   output logic               empty_o
);

   logic [ADDR_W-1:0]  mem_q [STACK_DEPTH];
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [IDX_W-1:0]   wr_idx, top_idx;
   logic               do_push, do_pop;

   assign full_o  = (depth_q == DEPTH_W'(STACK_DEPTH));
   assign empty_o = (depth_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign wr_idx  = IDX_W'(depth_q);
   assign top_idx = IDX_W'(depth_q - DEPTH_W'(1));
   assign top_o   = empty_o ? '0 : mem_q[top_idx];
   assign depth_o = depth_q;

   always_comb begin
      depth_d = depth_q;
      if (do_push)     depth_d = depth_q + DEPTH_W'(1);
      else if (do_pop) depth_d = depth_q - DEPTH_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) depth_q <= '0;
      else     depth_q <= depth_d;
   end

   // Entry storage carries no reset; stale entries are never read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_idx] <= push_data_i;
   end

endmodule

// File: rtl/pc_call_stack_unit.sv
// Program counter with load, increment, signed branch and call/return.
// Overflow and underflow attempts hold the PC and set a sticky error flag.
module pc_call_stack_unit
   import pc_pkg::*;
#(
   parameter int ADDR_W      = PC_ADDR_W_DEF,
   parameter int STACK_DEPTH = PC_STACK_DEPTH_DEF,
   parameter int RESET_PC    = PC_RESET_PC_DEF,
   parameter int INC_STEP    = PC_INC_STEP_DEF,
   localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               LoadPC,
   input  logic               IncPC,
   input  logic               BranchPC,
   input  logic               CallPC,
   input  logic               RetPC,
   input  logic [ADDR_W-1:0]  new_count,
   input  logic [ADDR_W-1:0]  offset,
   output logic [ADDR_W-1:0]  count,
   output logic [DEPTH_W-1:0] depth,
   output logic               stack_full,
   output logic               stack_empty,
   output logic               stack_err
);

   pc_op_t            op;
   logic [ADDR_W-1:0] count_q, count_d;
   logic [ADDR_W-1:0] ret_addr, stack_top;
   logic              err_q, err_d;
   logic              push, pop;

   assign op       = pc_decode(LoadPC, CallPC, RetPC, BranchPC, IncPC);
   assign ret_addr = count_q + ADDR_W'(INC_STEP);
   assign push     = (op == PC_CALL);
   assign pop      = (op == PC_RET);

   pc_ret_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk         (clk),
      .rst         (reset),
      .push_i      (push),
      .pop_i       (pop),
      .push_data_i (ret_addr),
      .top_o       (stack_top),
      .depth_o     (depth),
      .full_o      (stack_full),
      .empty_o     (stack_empty)
   );

   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      unique case (op)
         PC_LOAD:   count_d = new_count;
         PC_CALL: begin
            if (stack_full) err_d   = 1'b1;
            else            count_d = new_count;
         end
         PC_RET: begin
            if (stack_empty) err_d   = 1'b1;
            else             count_d = stack_top;
         end
         // Modulo add; the offset's two's-complement encoding makes it signed.
         PC_BRANCH: count_d = count_q + offset;
         PC_INC:    count_d = ret_addr;
         default:   count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= ADDR_W'(RESET_PC);
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign count     = count_q;
   assign stack_err = err_q;

endmodule

// File: tb/tb_pc_call_stack_unit.sv
// Directed bench for pc_call_stack_unit: expectations queued at drive time, checked after the edge.
module tb_pc_call_stack_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       LoadPC = 0, IncPC = 0, BranchPC = 0, CallPC = 0, RetPC = 0;
   logic [7:0] new_count = '0, offset = '0;
   logic [7:0] count;
   logic [2:0] depth;
   logic       stack_full, stack_empty, stack_err;

   int tests = 0;
   int failed = 0;

   typedef struct {
      string      tag;
      logic [7:0] c;
      logic [2:0] d;
      logic       err;
   } exp_t;

   exp_t exp_q[$];

   pc_call_stack_unit #(
      .ADDR_W(8), .STACK_DEPTH(4), .RESET_PC(0), .INC_STEP(1)
   ) dut (
      .clk(clk), .reset(reset),
      .LoadPC(LoadPC), .IncPC(IncPC), .BranchPC(BranchPC),
      .CallPC(CallPC), .RetPC(RetPC),
      .new_count(new_count), .offset(offset),
      .count(count), .depth(depth),
      .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input string fld,
                      input logic [7:0] got, input logic [7:0] want);
      tests++;
      assert (got === want) else begin
         failed++;
         $error("FAIL %s.%s got %h expected %h", tag, fld, got, want);
      end
   endtask

   task automatic expect_push(input string tag, input logic [7:0] c,
                              input logic [2:0] d, input logic err);
      exp_t e;
      e.tag = tag; e.c = c; e.d = d; e.err = err;
      exp_q.push_back(e);
   endtask

   task automatic check_pop();
      exp_t e;
      tests++;
      assert (exp_q.size() != 0) else begin
         failed++;
         $error("FAIL scoreboard got empty queue expected an entry");
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk(e.tag, "count", count, e.c);
         chk(e.tag, "depth", {5'b0, depth}, {5'b0, e.d});
         chk(e.tag, "full",  {7'b0, stack_full},  {7'b0, e.d == 3'd4});
         chk(e.tag, "empty", {7'b0, stack_empty}, {7'b0, e.d == 3'd0});
         chk(e.tag, "err",   {7'b0, stack_err},   {7'b0, e.err});
      end
   endtask

   // Drive one cycle of strobes at the falling edge, check after the rising edge.
   task automatic step(input string tag, input logic ld, input logic cl,
                       input logic rt, input logic br, input logic inc,
                       input logic [7:0] nc, input logic [7:0] off,
                       input logic [7:0] ec, input logic [2:0] ed, input logic ee);
      @(negedge clk);
      LoadPC = ld; CallPC = cl; RetPC = rt; BranchPC = br; IncPC = inc;
      new_count = nc; offset = off;
      expect_push(tag, ec, ed, ee);
      @(posedge clk);
      #1;
      check_pop();
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      LoadPC = 0; CallPC = 0; RetPC = 0; BranchPC = 0; IncPC = 0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      expect_push(tag, 8'h00, 3'd0, 1'b0);
      #1;
      check_pop();
   endtask

   initial begin
      do_reset("reset_state");

      step("load11", 1,0,0,0,0, 8'h11, 8'h00, 8'h11, 3'd0, 0);
      step("inc1",   0,0,0,0,1, 8'h00, 8'h00, 8'h12, 3'd0, 0);
      step("inc2",   0,0,0,0,1, 8'h00, 8'h00, 8'h13, 3'd0, 0);
      step("inc3",   0,0,0,0,1, 8'h00, 8'h00, 8'h14, 3'd0, 0);
      step("hold",   0,0,0,0,0, 8'h99, 8'h07, 8'h14, 3'd0, 0);
      step("loadFF", 1,0,0,0,0, 8'hFF, 8'h00, 8'hFF, 3'd0, 0);
      step("incwrap",0,0,0,0,1, 8'h00, 8'h00, 8'h00, 3'd0, 0);
      step("ld_inc", 1,0,0,0,1, 8'h11, 8'h00, 8'h11, 3'd0, 0);

      // Asynchronous reset while clock is low and LoadPC is asserted.
      @(negedge clk);
      LoadPC = 1; new_count = 8'h77;
      #2 reset = 1'b1;
      expect_push("async_rst", 8'h00, 3'd0, 0);
      #1 check_pop();
      @(posedge clk);
      expect_push("rst_held", 8'h00, 3'd0, 0);
      #1 check_pop();
      @(negedge clk);
      reset = 1'b0; LoadPC = 0;

      step("load20", 1,0,0,0,0, 8'h20, 8'h00, 8'h20, 3'd0, 0);
      step("br_p5",  0,0,0,1,0, 8'h00, 8'h05, 8'h25, 3'd0, 0);
      step("br_mF0", 0,0,0,1,0, 8'h00, 8'hF0, 8'h15, 3'd0, 0);
      step("load02", 1,0,0,0,0, 8'h02, 8'h00, 8'h02, 3'd0, 0);
      step("br_mFC", 0,0,0,1,0, 8'h00, 8'hFC, 8'hFE, 3'd0, 0);
      step("br_inc", 0,0,0,1,1, 8'h00, 8'h03, 8'h01, 3'd0, 0);

      step("load10", 1,0,0,0,0, 8'h10, 8'h00, 8'h10, 3'd0, 0);
      step("call40", 0,1,0,0,0, 8'h40, 8'h00, 8'h40, 3'd1, 0);
      step("call80", 0,1,0,0,0, 8'h80, 8'h00, 8'h80, 3'd2, 0);
      step("ret41",  0,0,1,0,0, 8'h00, 8'h00, 8'h41, 3'd1, 0);
      step("ret11",  0,0,1,0,0, 8'h00, 8'h00, 8'h11, 3'd0, 0);

      step("ldFFc",  1,0,0,0,0, 8'hFF, 8'h00, 8'hFF, 3'd0, 0);
      step("callwr", 0,1,0,0,0, 8'h50, 8'h00, 8'h50, 3'd1, 0);
      step("retwr",  0,0,1,1,1, 8'h00, 8'h09, 8'h00, 3'd0, 0);

      step("load11b",1,0,0,0,0, 8'h11, 8'h00, 8'h11, 3'd0, 0);
      step("ov_c1",  0,1,0,0,0, 8'h10, 8'h00, 8'h10, 3'd1, 0);
      step("ov_c2",  0,1,0,0,0, 8'h20, 8'h00, 8'h20, 3'd2, 0);
      step("ov_c3",  0,1,0,0,0, 8'h30, 8'h00, 8'h30, 3'd3, 0);
      step("ov_c4",  0,1,1,0,0, 8'h40, 8'h00, 8'h40, 3'd4, 0);
      step("ov_c5",  0,1,0,0,0, 8'hAA, 8'h00, 8'h40, 3'd4, 1);
      step("ov_r1",  0,0,1,0,0, 8'h00, 8'h00, 8'h31, 3'd3, 1);
      step("ov_r2",  0,0,1,0,0, 8'h00, 8'h00, 8'h21, 3'd2, 1);

      do_reset("reset2");
      step("un_ret", 0,0,1,0,0, 8'h00, 8'h00, 8'h00, 3'd0, 1);
      step("un_stky",0,0,0,0,1, 8'h00, 8'h00, 8'h01, 3'd0, 1);
      do_reset("reset3");
      step("ret_ld", 1,0,1,0,0, 8'h33, 8'h00, 8'h33, 3'd0, 0);
      step("call_ld",1,1,0,0,0, 8'h44, 8'h00, 8'h44, 3'd0, 0);

      @(negedge clk);
      LoadPC = 0; CallPC = 0; RetPC = 0; BranchPC = 0; IncPC = 0;
      tests++;
      assert (exp_q.size() == 0) else begin
         failed++;
         $error("FAIL scoreboard_drain got %0d leftover expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
